// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_t;

  localparam int          ADDR_W_DEF   = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [31:0] NOP_INSN     = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch: requests one word, holds it in ir until the
// core retires it, then follows the sequential or branch-redirected pc.
//
// state | meaning
// REQ   | present imem_req with imem_addr = pc
// WAIT  | request outstanding, waiting for imem_ack
// HOLD  | ir valid, waiting for the core to retire it
// FLUSH | outstanding request to be discarded after a redirect
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_f,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              br_taken,
  input  logic              br_rel,
  input  logic [15:0]       br_imm
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, ir_pc_nxt, br_target;
  logic [31:0]       ir_nxt;
  logic              ir_valid_nxt;
  logic              req_en;
  logic              capture;
  logic              retire;

  // req_en keeps the request low until the first edge after reset release,
  // so a stale ack from an abandoned fetch cannot be captured.
  assign retire    = ir_valid & ir_ready;
  assign capture   = imem_ack & (((state == ST_REQ) & req_en) | (state == ST_WAIT));
  assign br_target = br_rel ? (ir_pc + ADDR_W'(1) + ADDR_W'($signed(br_imm)))
                            : ADDR_W'(br_imm);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state    <= ST_REQ;
      pc       <= RESET_PC;
      ir       <= NOP_INSN;
      ir_pc    <= RESET_PC;
      ir_valid <= 1'b0;
      req_en   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      ir       <= ir_nxt;
      ir_pc    <= ir_pc_nxt;
      ir_valid <= ir_valid_nxt;
      req_en   <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    ir_nxt       = ir;
    ir_pc_nxt    = ir_pc;
    ir_valid_nxt = ir_valid;
    imem_req     = 1'b0;

    case (state)
      ST_REQ: begin
        imem_req = req_en;
        if (req_en) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        imem_req = 1'b1;
      end
      ST_HOLD: begin
        if (retire) begin
          ir_valid_nxt = 1'b0;
          state_nxt    = ST_REQ;
          if (br_taken) pc_nxt = br_target;
        end
      end
      ST_FLUSH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_REQ;
    endcase

    if (capture) begin
      ir_nxt       = imem_data;
      ir_pc_nxt    = pc;
      ir_valid_nxt = 1'b1;
      pc_nxt       = pc + ADDR_W'(1);
      state_nxt    = ST_HOLD;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a transaction-level pc/ir model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] ir;
  logic        ir_valid;
  logic [15:0] ir_pc;
  logic        ir_ready;
  logic        br_taken;
  logic        br_rel;
  logic [15:0] br_imm;

  int checks = 0;
  int errors = 0;

  // model: next fetch address, and what the held instruction should be
  logic [15:0] m_pc;
  logic [15:0] m_ir_pc;
  logic [31:0] m_ir;

  fetch_unit dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .ir_pc     (ir_pc),
    .ir_ready  (ir_ready),
    .br_taken  (br_taken),
    .br_rel    (br_rel),
    .br_imm    (br_imm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lat = number of cycles after the request cycle before ack (0 = ack in the request cycle)
  task automatic fetch(input int lat, input logic [31:0] data);
    check("req_rise", 32'(imem_req), 32'd1);
    check("req_addr", 32'(imem_addr), 32'(m_pc));
    check("no_ir_yet", 32'(ir_valid), 32'd0);
    for (int i = 0; i < lat; i++) begin
      ir_ready = 1'($urandom_range(0, 1));
      br_taken = 1'($urandom_range(0, 1));
      br_imm   = 16'($urandom);
      step();
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_stable", 32'(imem_addr), 32'(m_pc));
      check("ir_invalid_wait", 32'(ir_valid), 32'd0);
    end
    ir_ready  = 1'b0;
    br_taken  = 1'b0;
    imem_ack  = 1'b1;
    imem_data = data;
    step();
    imem_ack  = 1'b0;
    imem_data = $urandom;
    m_ir    = data;
    m_ir_pc = m_pc;
    m_pc    = m_pc + 16'd1;
    check("ir_valid_rise", 32'(ir_valid), 32'd1);
    check("ir_word", ir, m_ir);
    check("ir_pc", 32'(ir_pc), 32'(m_ir_pc));
    check("req_drop", 32'(imem_req), 32'd0);
  endtask

  task automatic retire(input int hold, input logic taken, input logic rel, input logic [15:0] imm);
    int s;
    int t;
    for (int i = 0; i < hold; i++) begin
      ir_ready  = 1'b0;
      br_taken  = 1'($urandom_range(0, 1));
      imem_ack  = 1'($urandom_range(0, 1));
      imem_data = $urandom;
      step();
      check("hold_ir", ir, m_ir);
      check("hold_valid", 32'(ir_valid), 32'd1);
      check("hold_pc", 32'(ir_pc), 32'(m_ir_pc));
      check("hold_noreq", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0;
    ir_ready = 1'b1;
    br_taken = taken;
    br_rel   = rel;
    br_imm   = imm;
    if (taken) begin
      if (rel) begin
        s = int'(imm);
        if (s >= 32768) s = s - 65536;
        t = (int'(m_ir_pc) + 1 + s) % 65536;
        if (t < 0) t = t + 65536;
        m_pc = t[15:0];
      end else begin
        m_pc = imm;
      end
    end
    step();
    ir_ready = 1'b0;
    br_taken = 1'b0;
    check("retire_valid", 32'(ir_valid), 32'd0);
    check("retire_req", 32'(imem_req), 32'd1);
    check("next_addr", 32'(imem_addr), 32'(m_pc));
  endtask

  initial begin
    rst_f     = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    ir_ready  = 1'b0;
    br_taken  = 1'b0;
    br_rel    = 1'b0;
    br_imm    = 16'h0;
    m_pc      = 16'h0000;
    m_ir      = 32'h0;
    m_ir_pc   = 16'h0000;

    #12;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(ir_valid), 32'd0);
    check("rst_ir", ir, 32'h0);
    check("rst_ir_pc", 32'(ir_pc), 32'h0);
    #11 rst_f = 1'b1;
    step();

    // basic fetch with 1-cycle memory, then sequential retire
    fetch(1, 32'h8800_0001);
    retire(0, 1'b0, 1'b0, 16'h0);
    // 3-cycle memory, then absolute branch to 5
    fetch(3, 32'h1234_5678);
    retire(2, 1'b1, 1'b0, 16'h0005);
    // relative branch backward from 5: 5 + 1 - 4 = 2
    fetch(2, 32'hCAFE_0005);
    retire(1, 1'b1, 1'b1, 16'hFFFC);
    fetch(1, 32'hCAFE_0002);
    retire(0, 1'b1, 1'b0, 16'h0040);
    // pc wrap from FFFF to 0
    fetch(1, 32'hCAFE_0040);
    retire(0, 1'b1, 1'b0, 16'hFFFF);
    fetch(2, 32'hCAFE_FFFF);
    retire(1, 1'b0, 1'b0, 16'h0);
    // ack arriving in the request cycle itself
    fetch(0, 32'hA5A5_0000);
    retire(0, 1'b0, 1'b1, 16'h7777);

    // reset during an outstanding request, ack while reset low and just after
    check("pre_rst_req", 32'(imem_req), 32'd1);
    step();
    check("wait_req", 32'(imem_req), 32'd1);
    rst_f = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_valid", 32'(ir_valid), 32'd0);
    check("midrst_ir", ir, 32'h0);
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #3 rst_f = 1'b1;
    @(posedge clk);
    #1 imem_ack = 1'b0;
    m_pc = 16'h0000;
    check("late_ack_valid", 32'(ir_valid), 32'd0);
    check("late_ack_ir", ir, 32'h0);
    fetch(1, 32'h0BAD_F00D);
    retire(0, 1'b0, 1'b0, 16'h0);

    // randomized fetch/retire traffic
    for (int n = 0; n < 40; n++) begin
      fetch($urandom_range(0, 4), $urandom);
      retire($urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
